// File: rtl/switch_debounce.sv
// Conditions raw slide-switch inputs: two-flop synchronizer per bit, then an independent
// counter debounce per bit, with a one-cycle strobe whenever the clean word changes.
module switch_debounce #(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] SWITCH,
  output logic [WIDTH-1:0] sw_clean,
  output logic             sw_changed
);

  localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_clean;
  logic             r_changed;
  logic [CNT_W-1:0] r_cnt [WIDTH];

  logic [WIDTH-1:0] w_nextClean;
  logic [CNT_W-1:0] w_nextCnt [WIDTH];

  // A bit only flips after its synchronized level has disagreed for STABLE_CYCLES edges in a row.
  always_comb begin
    w_nextClean = r_clean;
    for (int i = 0; i < WIDTH; i++) begin
      w_nextCnt[i] = '0;
      if (r_s2[i] != r_clean[i]) begin
        if (r_cnt[i] == LAST) begin
          w_nextClean[i] = r_s2[i];
        end else begin
          w_nextCnt[i] = r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_clean   <= '0;
      r_changed <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_s1      <= SWITCH;
      r_s2      <= r_s1;
      r_clean   <= w_nextClean;
      r_changed <= |(w_nextClean ^ r_clean);
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= w_nextCnt[i];
      end
    end
  end

  assign sw_clean   = r_clean;
  assign sw_changed = r_changed;

endmodule
